// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, NOP encoding, default reset PC
// and the IF/ID output slot payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IF/ID slot handed to decode
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_slot_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection (redirect / +4 / hold),
// redirect alignment and the sticky misaligned-redirect fault flag.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   redirect_valid    execute requests a PC change (highest priority)
//   redirect_pc       redirect target; low two bits are dropped
//   advance           output slot is loading, step to the next word
//   pc                current fetch PC
//   pc_plus4_c        pc + 4, wrapping, combinational
//   fault             sticky: a misaligned redirect was seen
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic            fault
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  assign pc_plus4_c = pc_q + XLEN'(4);

  // Next-PC mux and fault capture
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else if (advance) begin
      pc_d = pc_plus4_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC to instruction memory and captures the returned
// word into a registered IF/ID slot with a valid/ready handshake to decode.
// Redirects from execute flush the slot and reload the PC.
// Optional feature macro: FETCH_COUNT_EN (accepted-instruction counter on
// fetch_count; when undefined fetch_count reads 0).
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   imem_addr / imem_rdata         combinational instruction memory port
//   redirect_valid / redirect_pc   PC change request from execute
//   if_valid / if_ready            slot handshake toward decode
//   if_instr, if_pc, if_pc_plus4   slot contents
//   fetch_fault                    sticky misaligned-redirect flag
//   fetch_count                    accepted instruction count
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_count
);

  ifid_slot_t      slot_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4_c;
  logic            load_c;

  // Slot may take a new word when empty or being consumed this cycle
  assign load_c = !slot_q.valid || if_ready;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load_c),
    .pc             (pc),
    .pc_plus4_c     (pc_plus4_c),
    .fault          (fetch_fault)
  );

  assign imem_addr = pc;

  // Output slot: flush on redirect, otherwise capture on load, else hold.
  // pc+4 is registered alongside so if_pc_plus4 is a plain flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
      pc4_q  <= XLEN'(4);
    end else if (redirect_valid) begin
      slot_q.valid <= 1'b0;
    end else if (load_c) begin
      slot_q <= '{valid: 1'b1, instr: imem_rdata, pc: pc};
      pc4_q  <= pc_plus4_c;
    end
  end

  assign if_valid    = slot_q.valid;
  assign if_instr    = slot_q.instr;
  assign if_pc       = slot_q.pc;
  assign if_pc_plus4 = pc4_q;

`ifdef FETCH_COUNT_EN
  logic [XLEN-1:0] count_q;

  // Counts handshakes, including one that coincides with a redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (slot_q.valid && if_ready) begin
      count_q <= count_q + XLEN'(1);
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V core. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned word into a registered IF/ID output slot with a valid/ready handshake toward decode. Branch and jump redirects from execute flush the slot and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- imem_addr  out  32  fetch address to instruction memory; equals pc_q, combinational.
- imem_rdata  in  32  instruction word returned by memory in the same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  output slot holds a valid instruction.
- if_ready  in  1  decode accepts the slot this cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
- fetch_fault  out  1  sticky flag: a misaligned redirect was seen.
- fetch_count  out  32  count of accepted instructions. Behaviour depends on the macro in Configuration.

## Operation
- State:
  - pc_q
  - slot {valid, instr, pc}
  - fault_q
  - optional count_q
- load = !if_valid || if_ready.
- Priority 1, redirect_valid = 1:
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - slot.valid <= 0. This is a flush, applied regardless of if_ready.
  - If redirect_pc[1:0] != 0, fault_q <= 1.
- Priority 2, load = 1:
  - slot <= {1, imem_rdata, pc_q}.
  - pc_q <= pc_q + 4.
- Otherwise, stall: pc_q and slot hold.
- if_valid may fall without a handshake only on a redirect.
- While a stall holds, if_instr and if_pc must stay stable.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0.
- fault_q clears only on reset. Fetch continues at the aligned address after a fault.
- Reset values:
  - pc_q = RESET_PC.
  - if_valid = 0.
  - if_instr = 32'h0000_0013 (NOP).
  - if_pc = 0, so if_pc_plus4 = 4.
  - fetch_fault = 0.
  - fetch_count = 0.

## Timing
- Reset is asynchronous. Outputs reach their reset values immediately on assertion, including when asserted mid-stall or mid-redirect.
- Fetch latency is 1 cycle. The word at imem_addr in cycle N appears on if_instr with if_valid = 1 after edge N+1.
- First cycle after reset deassert: imem_addr = RESET_PC and if_valid = 0. Valid is asserted after the next edge.
- Redirect penalty: redirect in cycle N, then if_valid = 0 in N+1 and imem_addr = target in N+1. The target instruction is valid in N+2.
- Throughput: one instruction per cycle while if_ready = 1.
- Redirect in the same cycle as a handshake: the handshake completes, meaning decode consumed the slot. The flush then applies to the next content.

## Configuration
- FETCH_COUNT_EN defined:
  - count_q increments on each cycle where if_valid && if_ready.
  - Wraps modulo 2^32.
  - Driven to fetch_count.
- FETCH_COUNT_EN undefined:
  - No counter register.
  - fetch_count tied to 32'h0.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - DEFAULT_RESET_PC.
  - The IF/ID slot typedef {valid, instr, pc}.
- Sub-module fetch_pc_reg is natural. It holds the PC register, the next-PC mux (redirect / +4 / hold) and the alignment and fault logic.
- The top level holds the output slot, the handshake and the optional counter.

## Test plan
- Program loaded, reset released, if_ready = 1:
  - Slots are pc 0 / 00B00093, then pc 4 / 00000113, then pc 8 / 00100193 on consecutive cycles.
  - fetch_count = 3 with FETCH_COUNT_EN defined.
- if_ready = 0 for 3 cycles while the slot holds pc 8:
  - if_instr stays 00100193 and imem_addr stays 12.
  - On release, pc 12 / 00200293 follows.
- redirect_valid = 1 with redirect_pc = 0x10 while if_ready = 0:
  - Next cycle if_valid = 0 and imem_addr = 0x10.
  - The cycle after: if_pc = 0x10, if_instr = 00310233.
- redirect_pc = 0x12:
  - fetch_fault = 1 and stays 1.
  - Fetch resumes at 0x10.
- RESET_PC = 32'hFFFF_FFFC, run 2 cycles:
  - if_pc goes 0xFFFF_FFFC then 0x0.
  - if_pc_plus4 = 0 on the first slot.
- reset asserted mid-stall with if_valid = 1:
  - Immediately if_valid = 0, if_instr = 00000013, fetch_fault = 0.
  - After release, fetch restarts at RESET_PC.
